// File: rtl/fp32_pkg.sv
// Shared IEEE-754 binary32 definitions for the FPU functional units.
// Contents: field widths, canonical special encodings, the fp32_t field view,
// the operand class enum and a classifier that flushes denormals to ZERO.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  localparam logic [31:0] FP_NINF = 32'hFF800000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  // Exponent 0 covers both true zero and denormals; denormals count as zero.
  function automatic fp_class_t fp_classify(input fp32_t x);
    if (x.exp == '0) return ZERO;
    if (x.exp == '1) return (x.man != '0) ? NAN : INF;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for a 28-bit value.
// Ports:
//   value  in  28  vector to scan, bit 27 is the most significant
//   count  out 5   number of leading zeros, 28 when value is all zero
module fp_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// IEEE-754 binary32 adder/subtractor, fully pipelined, fixed 7-cycle latency.
// An operand pair captured on edge N has its result and flags on the outputs
// after edge N+7. One op per clock, no handshake, no stall.
// Ports:
//   clock      in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset, clears every stage
//   add_sub    in   1   1 = dataa + datab, 0 = dataa - datab
//   dataa      in   32  operand A, binary32
//   datab      in   32  operand B, binary32
//   result     out  32  A op B, registered
//   zero       out  1   result is +/-0
//   nan        out  1   result is NaN
//   overflow   out  1   finite operands rounded to an infinite result
//   underflow  out  1   nonzero exact result flushed to +0
module fp_addsub_pipe
  import fp32_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        zero,
  output logic        nan,
  output logic        overflow,
  output logic        underflow
);

  // Sideband carried unchanged from S1 to S7.
  // sign: sign of the larger-magnitude operand; zsign: sign of an exact zero sum.
  typedef struct packed {
    logic      sign;
    logic      zsign;
    fp_class_t spec;
    logic      inf_sign;
  } side_t;

  // Round to nearest, ties to even; bit 24 of the return is the mantissa carry.
  function automatic logic [24:0] rne_round(input logic [23:0] man, input logic [2:0] grs);
    logic up;
    up = grs[2] & (grs[1] | grs[0] | man[0]);
    return {1'b0, man} + {24'd0, up};
  endfunction

  function automatic logic [31:0] sat_inf(input logic sign);
    return sign ? FP_NINF : FP_PINF;
  endfunction

  fp32_t               a_p0, b_p0;
  logic                add_sub_p0, vld_p0;

  fp32_t               b_eff_s1;
  fp_class_t           cls_a_s1, cls_b_s1;
  logic [30:0]         mag_a_s1, mag_b_s1, mag_l_s1, mag_s_s1;
  logic                swap_s1;
  side_t               side_s1;

  side_t               side_p1;
  logic                eff_sub_p1, vld_p1;
  logic [7:0]          exp_l_p1, exp_s_p1;
  logic [23:0]         man_l_p1, man_s_p1;

  logic [7:0]          ediff_s2;
  logic [4:0]          shamt_s2;
  logic [49:0]         ext_s2;

  side_t               side_p2;
  logic                eff_sub_p2, vld_p2;
  logic [7:0]          exp_p2;
  logic [26:0]         man_l_p2, man_s_p2;

  logic [27:0]         sum_s3;

  side_t               side_p3;
  logic                vld_p3;
  logic [7:0]          exp_p3;
  logic [27:0]         sum_p3;

  logic [4:0]          lzc_s4;

  side_t               side_p4;
  logic                vld_p4;
  logic [7:0]          exp_p4;
  logic [27:0]         sum_p4;
  logic [4:0]          lzc_p4;

  logic [27:0]         norm_s5;
  logic signed [9:0]   exp_s5;

  side_t               side_p5;
  logic                vld_p5, is_zero_p5;
  logic [23:0]         man_p5;
  logic [2:0]          grs_p5;
  logic signed [9:0]   exp_p5;

  logic [24:0]         rnd_s6;
  logic [22:0]         frac_s6;
  logic signed [9:0]   exp_s6;

  side_t               side_p6;
  logic                vld_p6, is_zero_p6;
  logic [22:0]         frac_p6;
  logic signed [9:0]   exp_p6;

  logic [31:0]         res_s7;
  logic                zero_s7, nan_s7, ovf_s7, unf_s7;

  // ---- S1: unpack, classify, sign fix, magnitude compare, swap ----
  always_comb begin
    b_eff_s1      = b_p0;
    b_eff_s1.sign = b_p0.sign ^ ~add_sub_p0;
    cls_a_s1      = fp_classify(a_p0);
    cls_b_s1      = fp_classify(b_eff_s1);
    mag_a_s1      = (cls_a_s1 == ZERO) ? 31'd0 : a_p0[30:0];
    mag_b_s1      = (cls_b_s1 == ZERO) ? 31'd0 : b_eff_s1[30:0];
    swap_s1       = mag_b_s1 > mag_a_s1;
    mag_l_s1      = swap_s1 ? mag_b_s1 : mag_a_s1;
    mag_s_s1      = swap_s1 ? mag_a_s1 : mag_b_s1;
    side_s1.sign     = swap_s1 ? b_eff_s1.sign : a_p0.sign;
    side_s1.zsign    = a_p0.sign & b_eff_s1.sign;
    side_s1.spec     = NORM;
    side_s1.inf_sign = 1'b0;
    if (cls_a_s1 == NAN || cls_b_s1 == NAN ||
        (cls_a_s1 == INF && cls_b_s1 == INF && a_p0.sign != b_eff_s1.sign)) begin
      side_s1.spec = NAN;
    end else if (cls_a_s1 == INF) begin
      side_s1.spec     = INF;
      side_s1.inf_sign = a_p0.sign;
    end else if (cls_b_s1 == INF) begin
      side_s1.spec     = INF;
      side_s1.inf_sign = b_eff_s1.sign;
    end
  end

  // ---- S2: exponent difference, alignment shift, sticky ----
  // A shift of 26 already pushes the whole small mantissa below the round bit.
  always_comb begin
    ediff_s2 = exp_l_p1 - exp_s_p1;
    shamt_s2 = (ediff_s2 > 8'd26) ? 5'd26 : ediff_s2[4:0];
    ext_s2   = {man_s_p1, 26'd0} >> shamt_s2;
  end

  // ---- S3: 27-bit mantissa add/subtract (operands swapped so result >= 0) ----
  always_comb begin
    sum_s3 = eff_sub_p2 ? ({1'b0, man_l_p2} - {1'b0, man_s_p2})
                        : ({1'b0, man_l_p2} + {1'b0, man_s_p2});
  end

  // ---- S4: leading-zero count ----
  fp_lzc28 u_lzc (
    .value (sum_p3),
    .count (lzc_s4)
  );

  // ---- S5: normalize, exponent adjust ----
  // Bit 27 of the sum is the carry position, hence the +1 before subtracting lzc.
  always_comb begin
    norm_s5 = sum_p4 << lzc_p4;
    exp_s5  = $signed({2'b00, exp_p4}) + 10'sd1 - $signed({5'b00000, lzc_p4});
  end

  // ---- S6: round, mantissa-overflow renormalize ----
  always_comb begin
    rnd_s6 = rne_round(man_p5, grs_p5);
    if (rnd_s6[24]) begin
      frac_s6 = rnd_s6[23:1];
      exp_s6  = exp_p5 + 10'sd1;
    end else begin
      frac_s6 = rnd_s6[22:0];
      exp_s6  = exp_p5;
    end
  end

  // ---- S7: special-case select, pack, flags ----
  // Flags are gated by vld so stages cleared by reset read as all-zero outputs.
  always_comb begin
    res_s7  = 32'd0;
    zero_s7 = 1'b0;
    nan_s7  = 1'b0;
    ovf_s7  = 1'b0;
    unf_s7  = 1'b0;
    if (side_p6.spec == NAN) begin
      res_s7 = FP_QNAN;
      nan_s7 = 1'b1;
    end else if (side_p6.spec == INF) begin
      res_s7 = sat_inf(side_p6.inf_sign);
    end else if (is_zero_p6) begin
      res_s7  = {side_p6.zsign, 31'd0};
      zero_s7 = 1'b1;
    end else if (exp_p6 >= 10'sd255) begin
      res_s7 = sat_inf(side_p6.sign);
      ovf_s7 = 1'b1;
    end else if (exp_p6 <= 10'sd0) begin
      zero_s7 = 1'b1;
      unf_s7  = 1'b1;
    end else begin
      res_s7 = {side_p6.sign, exp_p6[7:0], frac_p6};
    end
    if (!vld_p6) begin
      zero_s7 = 1'b0;
      nan_s7  = 1'b0;
      ovf_s7  = 1'b0;
      unf_s7  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      a_p0       <= '0;
      b_p0       <= '0;
      add_sub_p0 <= 1'b0;
      vld_p0     <= 1'b0;
      side_p1    <= '0;
      eff_sub_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      exp_l_p1   <= '0;
      exp_s_p1   <= '0;
      man_l_p1   <= '0;
      man_s_p1   <= '0;
      side_p2    <= '0;
      eff_sub_p2 <= 1'b0;
      vld_p2     <= 1'b0;
      exp_p2     <= '0;
      man_l_p2   <= '0;
      man_s_p2   <= '0;
      side_p3    <= '0;
      vld_p3     <= 1'b0;
      exp_p3     <= '0;
      sum_p3     <= '0;
      side_p4    <= '0;
      vld_p4     <= 1'b0;
      exp_p4     <= '0;
      sum_p4     <= '0;
      lzc_p4     <= '0;
      side_p5    <= '0;
      vld_p5     <= 1'b0;
      is_zero_p5 <= 1'b0;
      man_p5     <= '0;
      grs_p5     <= '0;
      exp_p5     <= '0;
      side_p6    <= '0;
      vld_p6     <= 1'b0;
      is_zero_p6 <= 1'b0;
      frac_p6    <= '0;
      exp_p6     <= '0;
      result     <= '0;
      zero       <= 1'b0;
      nan        <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      // ---- input capture ----
      a_p0       <= dataa;
      b_p0       <= datab;
      add_sub_p0 <= add_sub;
      vld_p0     <= 1'b1;
      // ---- S1 -> p1 ----
      side_p1    <= side_s1;
      eff_sub_p1 <= a_p0.sign ^ b_eff_s1.sign;
      vld_p1     <= vld_p0;
      exp_l_p1   <= mag_l_s1[30:23];
      exp_s_p1   <= mag_s_s1[30:23];
      man_l_p1   <= {|mag_l_s1[30:23], mag_l_s1[22:0]};
      man_s_p1   <= {|mag_s_s1[30:23], mag_s_s1[22:0]};
      // ---- S2 -> p2 ----
      side_p2    <= side_p1;
      eff_sub_p2 <= eff_sub_p1;
      vld_p2     <= vld_p1;
      exp_p2     <= exp_l_p1;
      man_l_p2   <= {man_l_p1, 3'b000};
      man_s_p2   <= {ext_s2[49:24], |ext_s2[23:0]};
      // ---- S3 -> p3 ----
      side_p3    <= side_p2;
      vld_p3     <= vld_p2;
      exp_p3     <= exp_p2;
      sum_p3     <= sum_s3;
      // ---- S4 -> p4 ----
      side_p4    <= side_p3;
      vld_p4     <= vld_p3;
      exp_p4     <= exp_p3;
      sum_p4     <= sum_p3;
      lzc_p4     <= lzc_s4;
      // ---- S5 -> p5 ----
      side_p5    <= side_p4;
      vld_p5     <= vld_p4;
      is_zero_p5 <= (sum_p4 == 28'd0);
      man_p5     <= norm_s5[27:4];
      grs_p5     <= {norm_s5[3], norm_s5[2], |norm_s5[1:0]};
      exp_p5     <= exp_s5;
      // ---- S6 -> p6 ----
      side_p6    <= side_p5;
      vld_p6     <= vld_p5;
      is_zero_p6 <= is_zero_p5;
      frac_p6    <= frac_s6;
      exp_p6     <= exp_s6;
      // ---- S7 -> outputs ----
      result     <= res_s7;
      zero       <= zero_s7;
      nan        <= nan_s7;
      overflow   <= ovf_s7;
      underflow  <= unf_s7;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe: reset state, exact 7-cycle
// latency, arithmetic/rounding/special-value vectors, a back-to-back stream
// and an asynchronous reset with ops in flight.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        add_sub;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        zero;
  logic        nan;
  logic        overflow;
  logic        underflow;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] F_Z = 4'b1000;
  localparam logic [3:0] F_N = 4'b0100;
  localparam logic [3:0] F_O = 4'b0010;
  localparam logic [3:0] F_U = 4'b0001;

  typedef struct {
    logic        as;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  fp_addsub_pipe dut (
    .clock     (clk),
    .rst       (rst),
    .add_sub   (add_sub),
    .dataa     (dataa),
    .datab     (datab),
    .result    (result),
    .zero      (zero),
    .nan       (nan),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    add_sub = v.as;
    dataa   = v.a;
    datab   = v.b;
  endtask

  initial begin
    rst     = 1'b1;
    add_sub = 1'b0;
    dataa   = 32'd0;
    datab   = 32'd0;

    //                as    a             b             result        flags
    vecs.push_back('{1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000}); // 1+2
    vecs.push_back('{1'b0, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000}); // 3-1
    vecs.push_back('{1'b1, 32'h40400000, 32'h3F800000, 32'h40800000, 4'b0000}); // 3+1
    vecs.push_back('{1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0000}); // tie, even
    vecs.push_back('{1'b1, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0000}); // above half
    vecs.push_back('{1'b0, 32'h41200000, 32'h41200000, 32'h00000000, F_Z});     // x-x
    vecs.push_back('{1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, F_N});     // inf-inf
    vecs.push_back('{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, F_O});     // overflow
    vecs.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, F_Z});     // +0 + +0
    vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, F_Z});     // -0 + -0
    vecs.push_back('{1'b1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_N});     // NaN in
    vecs.push_back('{1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000}); // inf+1
    vecs.push_back('{1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, F_N});     // inf-inf same sign
    vecs.push_back('{1'b1, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000}); // denormal in
    vecs.push_back('{1'b0, 32'h00C00000, 32'h00800000, 32'h00000000, F_Z | F_U}); // denormal out
    vecs.push_back('{1'b0, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000}); // 1-2
    vecs.push_back('{1'b1, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'b0000}); // sticky
    vecs.push_back('{1'b1, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0000}); // tie, odd
    vecs.push_back('{1'b1, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'b0000}); // carry renorm

    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, zero, nan, overflow, underflow}, 32'd0);

    // Exact latency: captured on the first edge after release, visible after the 8th.
    rst = 1'b0;
    drive(vecs[0]);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat_early_result", result, 32'd0);
    check("lat_early_flags", {28'd0, zero, nan, overflow, underflow}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_result", result, vecs[0].r);
    check("lat_flags", {28'd0, zero, nan, overflow, underflow}, {28'd0, vecs[0].f});

    // Each vector in isolation.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_result", i), result, vecs[i].r);
      check($sformatf("v%0d_flags", i), {28'd0, zero, nan, overflow, underflow}, {28'd0, vecs[i].f});
    end

    // Back-to-back stream of 10 ops; op c-8 is on the outputs at negedge c.
    for (int c = 0; c < 18; c++) begin
      if (c >= 8) begin
        check($sformatf("s%0d_result", c - 8), result, vecs[c - 8].r);
        check($sformatf("s%0d_flags", c - 8), {28'd0, zero, nan, overflow, underflow},
              {28'd0, vecs[c - 8].f});
      end
      if (c < 10) drive(vecs[c]);
      @(posedge clk);
      @(negedge clk);
    end

    // Four ops in flight, then an asynchronous reset between clock edges.
    for (int k = 0; k < 4; k++) begin
      drive(vecs[k]);
      @(posedge clk);
      if (k < 3) @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_flags", {28'd0, zero, nan, overflow, underflow}, 32'd0);
    add_sub = 1'b1;
    dataa   = 32'd0;
    datab   = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("flush%0d_result", c), result, 32'd0);
      check($sformatf("flush%0d_flags", c), {29'd0, nan, overflow, underflow}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
